// File: rtl/adder_arbiter_pkg.sv
// Shared constants for the adder arbiter: requester count, ID width and FSM encoding.
package adder_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/adder_arbiter_rca.sv
// Plain n-bit ripple-carry adder; the carry-out lands in sum[n].
module nBitRippleCarryAdder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n:0]   sum
);
  logic [n:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[n] = carry[n];
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets four requesters share one ripple-carry adder,
// one transaction at a time: capture (IDLE), add (ADD), hand off result (HOLD).
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic              res_valid,
  output logic [N:0]        res_data,
  output logic [ID_W-1:0]   res_id,
  input  logic              res_ready
);
  state_t          state, state_n;
  logic [ID_W-1:0] ptr, ptr_n;
  logic [ID_W-1:0] win, win_n;
  logic [ID_W-1:0] pick;
  logic            found;
  logic [N-1:0]    a_q, b_q, a_n, b_n;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];
  logic [NREQ-1:0] grant_n;
  logic            valid_n;
  logic [N:0]      data_n, sum;
  logic [ID_W-1:0] id_n;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = a_in[i*N +: N];
      b_arr[i] = b_in[i*N +: N];
    end
  end

  // Scan from ptr upward (mod 4); walking downward lets the nearest set bit win.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + ID_W'(k)]) begin
        found = 1'b1;
        pick  = ptr + ID_W'(k);
      end
    end
  end

  nBitRippleCarryAdder #(.n(N)) u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (sum)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    a_n     = a_q;
    b_n     = b_q;
    grant_n = '0;
    valid_n = res_valid;
    data_n  = res_data;
    id_n    = res_id;
    case (state)
      IDLE: begin
        if (found) begin
          state_n       = ADD;
          grant_n[pick] = 1'b1;
          a_n           = a_arr[pick];
          b_n           = b_arr[pick];
          win_n         = pick;
          ptr_n         = pick + ID_W'(1);
        end
      end
      ADD: begin
        state_n = HOLD;
        valid_n = 1'b1;
        data_n  = sum;
        id_n    = win;
      end
      HOLD: begin
        // Leaving HOLD returns every output to its idle (reset) value.
        if (res_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          data_n  = '0;
          id_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      win       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      ptr       <= ptr_n;
      win       <= win_n;
      a_q       <= a_n;
      b_q       <= b_n;
      grant     <= grant_n;
      res_valid <= valid_n;
      res_data  <= data_n;
      res_id    <= id_n;
    end
  end
endmodule
